// File: rtl/chroma_upsampling_if.sv
// Wishbone slave bus bundle for the chroma upsampler.
// master drives request signals, slave returns DAT_O and ACK_O.
interface chroma_upsampling_if;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic [31:0] ADR_I;
   logic        WE_I;
   logic        STB_I;
   logic        CYC_I;
   logic [3:0]  SEL_I;
   logic        ACK_O;

   modport master (
      output DAT_I, ADR_I, WE_I,
      output STB_I, CYC_I, SEL_I,
      input  DAT_O, ACK_O
   );

   modport slave (
      input  DAT_I, ADR_I, WE_I,
      input  STB_I, CYC_I, SEL_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/chroma_upsampling.sv
// 4:2:0 to 4:4:4 chroma upsampler, one 2x2 block per pass.
// Ports: CLK_I, RST_I (sync, active high), wb (Wishbone slave).
module chroma_upsampling (
   input logic              CLK_I,
   input logic              RST_I,
   chroma_upsampling_if.slave wb
);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_EXPAND = 2'd1,
      S_READY  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0][7:0]   y_q, y_d;
   logic [7:0]        cr_q, cr_d;
   logic [7:0]        cb_q, cb_d;
   logic [3:0][23:0]  pix_q, pix_d;
   logic [5:0]        lmask_q, lmask_d;
   logic [3:0]        rmask_q, rmask_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;

   logic [3:0]  adr;
   logic [1:0]  idx;
   logic        req, wr, rd;
   logic        smp_wr, clr, pix_rd;
   logic        done_rd;
   logic [5:0]  lm_set;
   logic [3:0]  rm_set;
   logic [31:0] rdata;
   logic [31:0] status;
   logic        unused_bits;

   assign unused_bits = ^{wb.DAT_I[31:8],
                          wb.ADR_I[31:4],
                          wb.SEL_I[3:1]};

   assign adr = wb.ADR_I[3:0];
   assign idx = adr[1:0];

   // ACK_O gates the next request so each one acks exactly once.
   assign req = wb.CYC_I & wb.STB_I & ~ack_q
              & (state_q != S_EXPAND);
   assign wr  = req & wb.WE_I & wb.SEL_I[0];
   assign rd  = req & ~wb.WE_I;

   assign smp_wr = wr & (adr <= 4'h5)
                 & (state_q == S_LOAD);
   assign clr    = wr & (adr == 4'hF)
                 & wb.DAT_I[0];
   assign pix_rd = rd & (adr[3:2] == 2'b10)
                 & (state_q == S_READY);

   assign lm_set = lmask_q | (6'd1 << adr[2:0]);
   assign rm_set = rmask_q | (4'd1 << idx);

   assign done_rd = pix_rd & (rm_set == 4'hF);

   assign status = {21'h0,
                    state_q == S_READY,
                    rmask_q, lmask_q};

   always_comb begin
      rdata = 32'h0;
      unique case (1'b1)
         adr[3:2] == 2'b10:
            if (state_q == S_READY)
               rdata = {8'h00, pix_q[idx]};
         adr == 4'hC:
            rdata = status;
         default:
            rdata = 32'h0;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) state_q <= S_LOAD;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD: begin
            if (clr)
               state_d = S_LOAD;
            else if (smp_wr && lm_set == 6'h3F)
               state_d = S_EXPAND;
         end
         S_EXPAND:
            state_d = S_READY;
         S_READY: begin
            if (clr || done_rd)
               state_d = S_LOAD;
         end
         default:
            state_d = S_LOAD;
      endcase
   end

   always_comb begin
      y_d     = y_q;
      cr_d    = cr_q;
      cb_d    = cb_q;
      pix_d   = pix_q;
      lmask_d = lmask_q;
      rmask_d = rmask_q;
      ack_d   = req;
      dat_d   = dat_q;

      if (req)
         dat_d = wb.WE_I ? 32'h0 : rdata;

      if (smp_wr) begin
         lmask_d = lm_set;
         unique case (1'b1)
            adr == 4'h4: cr_d = wb.DAT_I[7:0];
            adr == 4'h5: cb_d = wb.DAT_I[7:0];
            default:     y_d[idx] = wb.DAT_I[7:0];
         endcase
      end

      // nearest-neighbour: every pixel gets the block chroma
      if (state_q == S_EXPAND) begin
         for (int k = 0; k < 4; k++)
            pix_d[k] = {cb_q, cr_q, y_q[k]};
      end

      if (pix_rd)
         rmask_d = rm_set;

      if (clr || done_rd) begin
         lmask_d = 6'h0;
         rmask_d = 4'h0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         y_q     <= '0;
         cr_q    <= 8'h0;
         cb_q    <= 8'h0;
         pix_q   <= '0;
         lmask_q <= 6'h0;
         rmask_q <= 4'h0;
         ack_q   <= 1'b0;
         dat_q   <= 32'h0;
      end else begin
         y_q     <= y_d;
         cr_q    <= cr_d;
         cb_q    <= cb_d;
         pix_q   <= pix_d;
         lmask_q <= lmask_d;
         rmask_q <= rmask_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   assign wb.ACK_O = ack_q;
   assign wb.DAT_O = dat_q;

endmodule

// File: tb/tb_chroma_upsampling.sv
// Directed bench for chroma_upsampling.
// Drives Wishbone cycles and checks against hand values.
module tb_chroma_upsampling;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   chroma_upsampling_if bus_if ();

   chroma_upsampling dut (
      .CLK_I (clk),
      .RST_I (rst),
      .wb    (bus_if)
   );

   always #5 clk = ~clk;

   task automatic bus(
      input  logic        we,
      input  logic [3:0]  adr,
      input  logic [31:0] dat,
      input  logic [3:0]  sel,
      output logic [31:0] rdat
   );
      bit got;
      got  = 0;
      rdat = 32'hDEAD_BEEF;
      @(negedge clk);
      bus_if.WE_I  = we;
      bus_if.ADR_I = {28'h0, adr};
      bus_if.DAT_I = dat;
      bus_if.SEL_I = sel;
      bus_if.CYC_I = 1'b1;
      bus_if.STB_I = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.ACK_O) begin
            got  = 1;
            rdat = bus_if.DAT_O;
         end
      end
      bus_if.CYC_I = 1'b0;
      bus_if.STB_I = 1'b0;
      bus_if.WE_I  = 1'b0;
      if (!got) begin
         bad++;
         $display("FAIL bus_timeout adr=%h", adr);
      end
   endtask

   task automatic wr(input logic [3:0] a,
                     input logic [7:0] d);
      logic [31:0] r;
      bus(1'b1, a, {24'h0, d}, 4'b0001, r);
   endtask

   task automatic test_reset;
      logic [31:0] r;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus_if.ACK_O !== 1'b0) begin
         bad++;
         $display("FAIL rst_ack got=%b exp=0",
                  bus_if.ACK_O);
      end
      total++;
      if (bus_if.DAT_O !== 32'h0) begin
         bad++;
         $display("FAIL rst_dat got=%h exp=0",
                  bus_if.DAT_O);
      end
      @(negedge clk);
      rst = 1'b0;
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL rst_status got=%h exp=0", r);
      end
   endtask

   task automatic test_basic;
      logic [31:0] r;
      logic [31:0] exp [4];
      exp[0] = 32'h007F800A;
      exp[1] = 32'h007F8014;
      exp[2] = 32'h007F801E;
      exp[3] = 32'h007F8028;
      wr(4'h0, 8'd10);
      wr(4'h1, 8'd20);
      wr(4'h2, 8'd30);
      wr(4'h3, 8'd40);
      wr(4'h4, 8'h80);
      bus(1'b1, 4'h5, 32'h7F, 4'b0001, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL wr_dat got=%h exp=0", r);
      end
      for (int k = 0; k < 4; k++) begin
         bus(1'b0, 4'(8 + k), 32'h0, 4'h0, r);
         total++;
         if (r !== exp[k]) begin
            bad++;
            $display("FAIL basic_pix%0d got=%h exp=%h",
                     k, r, exp[k]);
         end
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL basic_status got=%h exp=0", r);
      end
   endtask

   task automatic test_order;
      logic [31:0] r;
      wr(4'h5, 8'h33);
      wr(4'h3, 8'h44);
      wr(4'h4, 8'h55);
      wr(4'h0, 8'h11);
      wr(4'h2, 8'h22);
      bus(1'b0, 4'h8, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL early_pix got=%h exp=0", r);
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0000_003D) begin
         bad++;
         $display("FAIL part_status got=%h exp=3d", r);
      end
      wr(4'h1, 8'h66);
      // ACK of the last write falls during EXPAND
      @(posedge clk);
      #1;
      total++;
      if (bus_if.ACK_O !== 1'b0) begin
         bad++;
         $display("FAIL expand_ack got=%b exp=0",
                  bus_if.ACK_O);
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0000_043F) begin
         bad++;
         $display("FAIL rdy_status got=%h exp=43f", r);
      end
      bus(1'b0, 4'hA, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0033_5522) begin
         bad++;
         $display("FAIL order_pix2 got=%h exp=335522",
                  r);
      end
      bus(1'b0, 4'h8, 32'h0, 4'h0, r);
      bus(1'b0, 4'h9, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0033_5566) begin
         bad++;
         $display("FAIL order_pix1 got=%h exp=335566",
                  r);
      end
      bus(1'b0, 4'hB, 32'h0, 4'h0, r);
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL order_end got=%h exp=0", r);
      end
   endtask

   task automatic test_ready;
      logic [31:0] r, r2;
      wr(4'h0, 8'h01);
      wr(4'h1, 8'h02);
      wr(4'h2, 8'h03);
      wr(4'h3, 8'h04);
      wr(4'h4, 8'h05);
      wr(4'h5, 8'h06);
      wr(4'h0, 8'hFF);
      bus(1'b0, 4'h8, 32'h0, 4'h0, r);
      bus(1'b0, 4'h8, 32'h0, 4'h0, r2);
      total++;
      if (r !== 32'h0006_0501 ||
          r2 !== 32'h0006_0501) begin
         bad++;
         $display("FAIL reread got=%h,%h exp=60501",
                  r, r2);
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0000_047F) begin
         bad++;
         $display("FAIL ready_mask got=%h exp=47f", r);
      end
      bus(1'b0, 4'hB, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0006_0504) begin
         bad++;
         $display("FAIL ready_pix3 got=%h exp=60504",
                  r);
      end
      bus(1'b0, 4'h9, 32'h0, 4'h0, r);
      bus(1'b0, 4'hA, 32'h0, 4'h0, r);
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL ready_end got=%h exp=0", r);
      end
   endtask

   task automatic test_clear;
      logic [31:0] r;
      wr(4'h0, 8'hA0);
      wr(4'h1, 8'hA1);
      wr(4'h4, 8'hA4);
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0000_0013) begin
         bad++;
         $display("FAIL pre_clr got=%h exp=13", r);
      end
      wr(4'hF, 8'h01);
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL soft_clr got=%h exp=0", r);
      end
      wr(4'h0, 8'hB0);
      wr(4'h1, 8'hB1);
      @(negedge clk);
      rst = 1'b1;
      bus_if.WE_I  = 1'b1;
      bus_if.ADR_I = 32'h2;
      bus_if.DAT_I = 32'hB2;
      bus_if.SEL_I = 4'b0001;
      bus_if.CYC_I = 1'b1;
      bus_if.STB_I = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus_if.ACK_O !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_ack got=%b exp=0",
                  bus_if.ACK_O);
      end
      @(negedge clk);
      rst = 1'b0;
      bus_if.CYC_I = 1'b0;
      bus_if.STB_I = 1'b0;
      bus_if.WE_I  = 1'b0;
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid got=%h exp=0", r);
      end
   endtask

   task automatic test_sel;
      logic [31:0] r;
      bus(1'b1, 4'h0, 32'h99, 4'b0010, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL sel_dat got=%h exp=0", r);
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL sel_mask got=%h exp=0", r);
      end
      wr(4'h3, 8'h77);
      bus(1'b0, 4'h7, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL rd_hole got=%h exp=0", r);
      end
      bus(1'b0, 4'hC, 32'h0, 4'h0, r);
      total++;
      if (r !== 32'h0000_0008) begin
         bad++;
         $display("FAIL sel_after got=%h exp=8", r);
      end
   endtask

   initial begin
      bus_if.DAT_I = 32'h0;
      bus_if.ADR_I = 32'h0;
      bus_if.WE_I  = 1'b0;
      bus_if.STB_I = 1'b0;
      bus_if.CYC_I = 1'b0;
      bus_if.SEL_I = 4'h0;
      test_reset();
      test_basic();
      test_order();
      test_ready();
      test_clear();
      test_sel();
      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
